// File: rtl/vector_bist.sv
// Sweeping BIST controller: walks all 2^N_IN stimulus vectors, compares resp against exp, tallies mismatches.
// Define VECTOR_BIST_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module vector_bist #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  resp,
    input  logic [N_OUT-1:0]  exp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       nerr,
    output logic [N_IN-1:0]   first_fail,
    output logic              fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] STIM_ZERO   = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] STIM_ONES   = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       nerr_q, nerr_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              fv_q, fv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mismatch_s;
    logic              last_vec_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    assign mismatch_s = (resp != exp);
    assign last_vec_s = (stim_q == STIM_ONES);

    // Next-state, datapath updates and registered-output precompute
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        nerr_d  = nerr_q;
        ff_d    = ff_q;
        fv_d    = fv_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    stim_d  = STIM_ZERO;
                    cnt_d   = 8'd0;
                    nerr_d  = 16'd0;
                    ff_d    = STIM_ZERO;
                    fv_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    nerr_d = sat_inc16(nerr_q);
                    if (!fv_q) begin
                        ff_d = stim_q;
                        fv_d = 1'b1;
                    end else begin
                        ff_d = ff_q;
                    end
                end else begin
                    nerr_d = nerr_q;
                end
`ifdef VECTOR_BIST_STOP_ON_FAIL_EN
                if (mismatch_s || last_vec_s) begin
`else
                if (last_vec_s) begin
`endif
                    // stim is held on the final (or failing) vector
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                    stim_d  = stim_q + STIM_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stim_d  = STIM_ZERO;
                cnt_d   = 8'd0;
                nerr_d  = 16'd0;
                ff_d    = STIM_ZERO;
                fv_d    = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_APPLY) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (nerr_d == 16'd0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stim_q  <= STIM_ZERO;
            cnt_q   <= 8'd0;
            nerr_q  <= 16'd0;
            ff_q    <= STIM_ZERO;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            nerr_q  <= nerr_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign nerr       = nerr_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule
